// File: rtl/action_input_if.sv
// rtl/action_input_if.sv - action offer handshake between input front-end and stats
interface action_input_if;
  logic       action_valid;
  logic       action_ready;
  logic [2:0] action_code;

  // Producer side: the action_input block offers coded actions
  modport master (
    output action_valid,
    output action_code,
    input  action_ready
  );

  // Consumer side: the stats block accepts coded actions
  modport slave (
    input  action_valid,
    input  action_code,
    output action_ready
  );
endinterface

// File: rtl/action_input.sv
// rtl/action_input.sv - button sync/debounce, press queue and cooled-down action offer
module action_input #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     btn_in,
  action_input_if.master act,
  output logic [7:0]     btn_stable,
  output logic [7:0]     pending,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [15:0] db_cnt [8];
  logic [7:0]  stable_d;
  logic [7:0]  press;

  state_t      state_q;
  state_t      state_d;
  logic        valid_q;
  logic        valid_d;
  logic [2:0]  code_q;
  logic [2:0]  code_d;
  logic [23:0] cd_cnt_q;
  logic [23:0] cd_cnt_d;
  logic [7:0]  clr;
  logic [2:0]  sel;

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the stable level flips only after a full run of disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == btn_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_stable[i] <= sync2[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Delayed copy of the debounced levels for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_d <= '0;
    else        stable_d <= btn_stable;
  end

  assign press = btn_stable & ~stable_d;

  // Pending requests: presses merge into a single bit, and a new press beats a same-edge clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr) | press;
  end

  // Lowest-index pending request gets served first
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) sel = 3'(i);
    end
  end

  // FSM state, offered action and cooldown counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      code_q   <= 3'd0;
      cd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      cd_cnt_q <= cd_cnt_d;
    end
  end

  // Next-state logic: pick a request, hold it until accepted, then sit out the cooldown
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    code_d   = code_q;
    cd_cnt_d = cd_cnt_q;
    clr      = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending != 8'd0) begin
          code_d  = sel;
          valid_d = 1'b1;
          clr     = 8'd1 << sel;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (act.action_ready) begin
          valid_d = 1'b0;
          if (COOLDOWN_CYCLES == 24'd0) begin
            state_d = ST_IDLE;
          end else begin
            cd_cnt_d = COOLDOWN_CYCLES - 24'd1;
            state_d  = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q == 24'd0) state_d = ST_IDLE;
        else                   cd_cnt_d = cd_cnt_q - 24'd1;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign act.action_valid = valid_q;
  assign act.action_code  = code_q;
  assign busy             = (state_q == ST_OFFER) || (state_q == ST_COOLDOWN);

endmodule

// File: tb/tb_action_input.sv
// tb/tb_action_input.sv - directed self-checking bench for action_input
module tb_action_input;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn_in;
  logic [7:0] btn_stable;
  logic [7:0] pending;
  logic       busy;

  int n_cmp;
  int n_err;
  int e;
  int busy_cnt;
  int valid_cnt;
  int bad_cnt;
  logic [7:0] or_acc;

  action_input_if aif ();

  action_input #(
    .DEBOUNCE_CYCLES(16'd4),
    .COOLDOWN_CYCLES(24'd8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .act        (aif),
    .btn_stable (btn_stable),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to edge n of the current scenario, sampling 1 time unit after the edge
  task automatic goto(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    e     = 0;
    rst_n = 1'b0;
    btn_in = 8'h00;
    aif.action_ready = 1'b1;

    // Reset state
    goto(3);
    chk("rst_valid",  {31'd0, aif.action_valid}, 32'd0);
    chk("rst_code",   {29'd0, aif.action_code},  32'd0);
    chk("rst_stable", {24'd0, btn_stable},       32'd0);
    chk("rst_pending",{24'd0, pending},          32'd0);
    chk("rst_busy",   {31'd0, busy},             32'd0);
    rst_n = 1'b1;
    goto(5);

    // Clean press of button 2
    e = 0;
    btn_in = 8'h04;
    goto(5);
    chk("clean_stable_e5", {24'd0, btn_stable}, 32'h00);
    goto(6);
    chk("clean_stable_e6", {24'd0, btn_stable}, 32'h04);
    chk("clean_pend_e6",   {24'd0, pending},    32'h00);
    goto(7);
    chk("clean_pend_e7",   {24'd0, pending},    32'h04);
    chk("clean_valid_e7",  {31'd0, aif.action_valid}, 32'd0);
    busy_cnt  = 0;
    valid_cnt = 0;
    goto(8);
    chk("clean_valid_e8",  {31'd0, aif.action_valid}, 32'd1);
    chk("clean_code_e8",   {29'd0, aif.action_code},  32'd2);
    chk("clean_pend_e8",   {24'd0, pending},          32'h00);
    busy_cnt  += int'(busy);
    valid_cnt += int'(aif.action_valid);
    while (e < 20) begin
      goto(e + 1);
      busy_cnt  += int'(busy);
      valid_cnt += int'(aif.action_valid);
    end
    chk("clean_busy_cycles",  busy_cnt,  32'd9);
    chk("clean_valid_cycles", valid_cnt, 32'd1);
    btn_in = 8'h00;
    goto(40);
    chk("clean_release_stable", {24'd0, btn_stable}, 32'h00);
    chk("clean_release_pend",   {24'd0, pending},    32'h00);

    // Glitch of 3 cycles on button 0
    e = 0;
    btn_in = 8'h01;
    goto(3);
    btn_in = 8'h00;
    or_acc = 8'h00;
    valid_cnt = 0;
    while (e < 16) begin
      goto(e + 1);
      or_acc    = or_acc | btn_stable | pending;
      valid_cnt += int'(aif.action_valid);
    end
    chk("glitch_stable_pend", {24'd0, or_acc}, 32'h00);
    chk("glitch_valid",       valid_cnt,       32'd0);

    // Priority: buttons 5 and 1 together
    e = 0;
    btn_in = 8'h22;
    goto(6);
    chk("prio_stable",   {24'd0, btn_stable}, 32'h22);
    goto(7);
    chk("prio_pend_e7",  {24'd0, pending},    32'h22);
    goto(8);
    chk("prio_valid_e8", {31'd0, aif.action_valid}, 32'd1);
    chk("prio_code_e8",  {29'd0, aif.action_code},  32'd1);
    chk("prio_pend_e8",  {24'd0, pending},          32'h20);
    goto(9);
    chk("prio_valid_e9", {31'd0, aif.action_valid}, 32'd0);
    goto(16);
    chk("prio_busy_e16", {31'd0, busy}, 32'd1);
    goto(17);
    chk("prio_busy_e17", {31'd0, busy}, 32'd0);
    chk("prio_pend_e17", {24'd0, pending}, 32'h20);
    goto(18);
    chk("prio_valid_e18", {31'd0, aif.action_valid}, 32'd1);
    chk("prio_code_e18",  {29'd0, aif.action_code},  32'd5);
    chk("prio_pend_e18",  {24'd0, pending},          32'h00);
    btn_in = 8'h00;
    goto(19);
    chk("prio_valid_e19", {31'd0, aif.action_valid}, 32'd0);
    chk("prio_code_hold", {29'd0, aif.action_code},  32'd5);
    goto(40);

    // Backpressure on button 3
    e = 0;
    aif.action_ready = 1'b0;
    btn_in = 8'h08;
    goto(8);
    chk("bp_valid_e8", {31'd0, aif.action_valid}, 32'd1);
    chk("bp_code_e8",  {29'd0, aif.action_code},  32'd3);
    bad_cnt = 0;
    while (e < 38) begin
      goto(e + 1);
      if (!(aif.action_valid === 1'b1 && aif.action_code === 3'd3)) bad_cnt++;
    end
    chk("bp_hold", bad_cnt, 32'd0);
    aif.action_ready = 1'b1;
    goto(39);
    chk("bp_valid_after", {31'd0, aif.action_valid}, 32'd0);
    chk("bp_busy_after",  {31'd0, busy},             32'd1);
    btn_in = 8'h00;
    valid_cnt = 0;
    while (e < 60) begin
      goto(e + 1);
      valid_cnt += int'(aif.action_valid);
    end
    chk("bp_single_xfer", valid_cnt, 32'd0);

    // Merge and re-arm on button 4
    e = 0;
    aif.action_ready = 1'b0;
    btn_in = 8'h10;
    goto(6);
    btn_in = 8'h00;
    goto(8);
    chk("merge_valid_e8", {31'd0, aif.action_valid}, 32'd1);
    chk("merge_code_e8",  {29'd0, aif.action_code},  32'd4);
    goto(12);
    btn_in = 8'h10;
    goto(18);
    btn_in = 8'h00;
    goto(19);
    chk("merge_pend_e19", {24'd0, pending}, 32'h10);
    goto(24);
    btn_in = 8'h10;
    goto(25);
    aif.action_ready = 1'b1;
    goto(26);
    chk("merge_valid_e26", {31'd0, aif.action_valid}, 32'd0);
    chk("merge_busy_e26",  {31'd0, busy},             32'd1);
    goto(31);
    chk("merge_pend_e31", {24'd0, pending}, 32'h10);
    goto(33);
    chk("merge_busy_e33", {31'd0, busy}, 32'd1);
    goto(34);
    chk("merge_busy_e34", {31'd0, busy}, 32'd0);
    goto(35);
    chk("merge_valid_e35", {31'd0, aif.action_valid}, 32'd1);
    chk("merge_code_e35",  {29'd0, aif.action_code},  32'd4);
    chk("merge_pend_e35",  {24'd0, pending},          32'h00);
    btn_in = 8'h00;
    valid_cnt = 0;
    while (e < 60) begin
      goto(e + 1);
      valid_cnt += int'(aif.action_valid);
    end
    chk("merge_no_extra", valid_cnt, 32'd0);

    // Asynchronous reset mid-cooldown with 8'h81 pending
    e = 0;
    btn_in = 8'h02;
    goto(3);
    btn_in = 8'h83;
    goto(11);
    chk("ar_pend_before", {24'd0, pending}, 32'h81);
    chk("ar_busy_before", {31'd0, busy},    32'd1);
    #2;
    rst_n = 1'b0;
    btn_in = 8'h00;
    #1;
    chk("ar_valid",   {31'd0, aif.action_valid}, 32'd0);
    chk("ar_code",    {29'd0, aif.action_code},  32'd0);
    chk("ar_stable",  {24'd0, btn_stable},       32'h00);
    chk("ar_pending", {24'd0, pending},          32'h00);
    chk("ar_busy",    {31'd0, busy},             32'd0);
    goto(13);
    rst_n = 1'b1;
    valid_cnt = 0;
    while (e < 35) begin
      goto(e + 1);
      valid_cnt += int'(aif.action_valid);
    end
    chk("ar_no_offer", valid_cnt, 32'd0);
    e = 0;
    btn_in = 8'h40;
    goto(8);
    chk("ar_new_valid", {31'd0, aif.action_valid}, 32'd1);
    chk("ar_new_code",  {29'd0, aif.action_code},  32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
